// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline stages and the central pipeline controller.
// The master side is the controller; the slave side is the datapath it steers.
interface pipe_ctrl_if #(
  parameter int NUM_IRQ = 8
);
  logic               if_busy;
  logic               mem_busy;
  logic               ld_hazard;
  logic               mem_en;
  logic [29:0]        mem_pc;
  logic               mem_exc;
  logic [3:0]         mem_exc_code;
  logic               mem_eret;
  logic [NUM_IRQ-1:0] irq;
  logic               csr_ie_we;
  logic               csr_ie_wdata;
  logic               if_stall;
  logic               id_stall;
  logic               ex_stall;
  logic               mem_stall;
  logic               if_flush;
  logic               id_flush;
  logic               ex_flush;
  logic               mem_flush;
  logic [29:0]        new_pc;
  logic [29:0]        epc;
  logic [4:0]         cause;
  logic               int_en;

  modport master (
    input  if_busy, mem_busy, ld_hazard, mem_en, mem_pc, mem_exc, mem_exc_code,
           mem_eret, irq, csr_ie_we, csr_ie_wdata,
    output if_stall, id_stall, ex_stall, mem_stall,
           if_flush, id_flush, ex_flush, mem_flush,
           new_pc, epc, cause, int_en
  );

  modport slave (
    output if_busy, mem_busy, ld_hazard, mem_en, mem_pc, mem_exc, mem_exc_code,
           mem_eret, irq, csr_ie_we, csr_ie_wdata,
    input  if_stall, id_stall, ex_stall, mem_stall,
           if_flush, id_flush, ex_flush, mem_flush,
           new_pc, epc, cause, int_en
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stage stall/flush, MEM-stage trap/eret/interrupt
// arbitration, redirect PC and the EPC/cause/interrupt-enable state.
module pipe_ctrl #(
  parameter logic [29:0] EXC_VEC = 30'h0000_0010,
  parameter int          NUM_IRQ = 8
) (
  input  logic          cpu_clk,
  input  logic          cpu_rstn,
  pipe_ctrl_if.master   pif
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             state_r;
  logic [NUM_IRQ-1:0] irq_meta_r;
  logic [NUM_IRQ-1:0] irq_sync_r;
  logic [29:0]        redirect_r;
  logic [29:0]        epc_r;
  logic [4:0]         cause_r;
  logic               int_en_r;

  logic               irq_pend_s;
  logic               ev_exc_s;
  logic               ev_eret_s;
  logic               ev_irq_s;
  logic               event_s;
  logic [3:0]         stall_s;   // {mem, ex, id, if}
  logic [3:0]         flush_s;   // {mem, ex, id, if}

  // Index of the lowest-numbered asserted request line.
  function automatic logic [3:0] lowest_irq(input logic [NUM_IRQ-1:0] req);
    lowest_irq = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lowest_irq = 4'(i);
      end
    end
  endfunction

  // MEM-stage event arbitration: exception beats eret beats interrupt.
  always_comb begin
    ev_exc_s   = 1'b0;
    ev_eret_s  = 1'b0;
    ev_irq_s   = 1'b0;
    irq_pend_s = int_en_r && (|irq_sync_r);
    if ((state_r == ST_RUN) && !pif.mem_busy && pif.mem_en) begin
      if (pif.mem_exc) begin
        ev_exc_s = 1'b1;
      end else if (pif.mem_eret) begin
        ev_eret_s = 1'b1;
      end else if (irq_pend_s) begin
        ev_irq_s = 1'b1;
      end else begin
        ev_irq_s = 1'b0;
      end
    end else begin
      ev_exc_s = 1'b0;
    end
    event_s = ev_exc_s | ev_eret_s | ev_irq_s;
  end

  // Stage hold/bubble selection; the redirect cycle overrides every hazard.
  always_comb begin
    stall_s = 4'b0000;
    flush_s = 4'b0000;
    if (state_r == ST_FLUSH) begin
      flush_s = 4'b1111;
    end else if (pif.mem_busy || event_s) begin
      stall_s = 4'b1111;
    end else if (pif.ld_hazard) begin
      stall_s = 4'b0011;
      flush_s = 4'b0100;
    end else if (pif.if_busy) begin
      stall_s = 4'b0001;
      flush_s = 4'b0010;
    end else begin
      stall_s = 4'b0000;
    end
  end

  assign pif.if_stall  = stall_s[0];
  assign pif.id_stall  = stall_s[1];
  assign pif.ex_stall  = stall_s[2];
  assign pif.mem_stall = stall_s[3];
  assign pif.if_flush  = flush_s[0];
  assign pif.id_flush  = flush_s[1];
  assign pif.ex_flush  = flush_s[2];
  assign pif.mem_flush = flush_s[3];
  assign pif.new_pc    = (state_r == ST_FLUSH) ? redirect_r : 30'd0;
  assign pif.epc       = epc_r;
  assign pif.cause     = cause_r;
  assign pif.int_en    = int_en_r;

  // Controller state, trap CSRs and the irq synchronizer.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_r    <= ST_RUN;
      irq_meta_r <= '0;
      irq_sync_r <= '0;
      redirect_r <= 30'd0;
      epc_r      <= 30'd0;
      cause_r    <= 5'd0;
      int_en_r   <= 1'b0;
    end else begin
      irq_meta_r <= pif.irq;
      irq_sync_r <= irq_meta_r;
      case (state_r)
        ST_RUN: begin
          if (ev_exc_s) begin
            epc_r      <= pif.mem_pc;
            cause_r    <= {1'b0, pif.mem_exc_code};
            int_en_r   <= 1'b0;
            redirect_r <= EXC_VEC;
            state_r    <= ST_FLUSH;
          end else if (ev_eret_s) begin
            redirect_r <= epc_r;
            int_en_r   <= 1'b1;
            state_r    <= ST_FLUSH;
          end else if (ev_irq_s) begin
            epc_r      <= pif.mem_pc;
            cause_r    <= {1'b1, lowest_irq(irq_sync_r)};
            int_en_r   <= 1'b0;
            redirect_r <= EXC_VEC;
            state_r    <= ST_FLUSH;
          end else if (pif.csr_ie_we) begin
            int_en_r <= pif.csr_ie_wdata;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

endmodule
